// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UP     = 2'd1,
        ST_DOWN   = 2'd2,
        ST_PAUSED = 2'd3
    } state_e;

    localparam int MODE_PINGPONG = 0;
    localparam int MODE_UPWRAP   = 1;
    localparam int MODE_DOWNWRAP = 2;

    localparam int RND_W = 16;

    // Bits needed to hold a prescale count of 0..max(up_div, down_div)-1.
    function automatic int cnt_width(input int up_div, input int down_div);
        int m;
        m = (up_div > down_div) ? up_div : down_div;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Prescaler: counts enabled cycles up to a run-time terminal value, then wraps.
module tick_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A tick only counts when enabled; a disabled counter parked on its
    // terminal value fires on the first enabled cycle afterwards.
    assign tick = en && (cnt_q == term);

    // Next count: clear wins, otherwise advance or wrap when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_sequencer.sv
// Up/down LED counter with ping-pong or wrap modes, pause, and round limit.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int UP_DIV   = 2000000,
    parameter int DOWN_DIV = 6000000,
    parameter int MODE     = 0,
    parameter int ROUNDS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             pause,
    output logic [WIDTH-1:0] value,
    output logic             dir,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    localparam int CNT_W = cnt_width(UP_DIV, DOWN_DIV);
    localparam logic [WIDTH-1:0] VAL_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] VAL_MAX_M1 = VAL_MAX - 1'b1;
    localparam logic [WIDTH-1:0] VAL_ONE    = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [RND_W-1:0] rnd_q, rnd_d, rnd_inc;
    logic             saved_up_q, saved_up_d;
    logic             done_q, done_d;
    logic             round_end;
    logic             dir_chg;
    logic             tick_en, tick_clr, tick;
    logic [CNT_W-1:0] tick_term;

    // Prescaler runs only while actively stepping; a pause pulse freezes it.
    assign tick_en   = ((state_q == ST_UP) || (state_q == ST_DOWN)) && !pause;
    assign dir_chg   = ((state_q == ST_UP)   && (state_d == ST_DOWN)) ||
                       ((state_q == ST_DOWN) && (state_d == ST_UP));
    assign tick_clr  = (state_q == ST_IDLE) || dir_chg;
    assign tick_term = dir ? CNT_W'(UP_DIV - 1) : CNT_W'(DOWN_DIV - 1);
    assign rnd_inc   = (rnd_q == {RND_W{1'b1}}) ? rnd_q : rnd_q + RND_W'(1);

    tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .term (tick_term),
        .tick (tick)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            rnd_q      <= '0;
            saved_up_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            rnd_q      <= rnd_d;
            saved_up_q <= saved_up_d;
            done_q     <= done_d;
        end
    end

    // Next state, value stepping and round bookkeeping.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        rnd_d      = rnd_q;
        saved_up_d = saved_up_q;
        done_d     = 1'b0;
        round_end  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    rnd_d = '0;
                    if (MODE == MODE_DOWNWRAP) begin
                        state_d = ST_DOWN;
                        value_d = VAL_MAX;
                    end else begin
                        state_d = ST_UP;
                        value_d = '0;
                    end
                end
            end
            ST_UP: begin
                if (pause) begin
                    state_d    = ST_PAUSED;
                    saved_up_d = 1'b1;
                end else if (tick) begin
                    if (value_q != VAL_MAX) begin
                        value_d = value_q + VAL_ONE;
                    end else if (MODE == MODE_PINGPONG) begin
                        state_d = ST_DOWN;
                        value_d = VAL_MAX_M1;
                    end else begin
                        round_end = 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                if (pause) begin
                    state_d    = ST_PAUSED;
                    saved_up_d = 1'b0;
                end else if (tick) begin
                    if (value_q != '0) begin
                        value_d = value_q - VAL_ONE;
                    end else begin
                        round_end = 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (pause) state_d = saved_up_q ? ST_UP : ST_DOWN;
            end
            default: state_d = ST_IDLE;
        endcase

        // Round end: finish after the last round, otherwise restart the sweep.
        if (round_end) begin
            rnd_d = rnd_inc;
            if ((ROUNDS != 0) && (rnd_inc == RND_W'(ROUNDS))) begin
                state_d = ST_IDLE;
                value_d = '0;
                done_d  = 1'b1;
            end else if (MODE == MODE_PINGPONG) begin
                state_d = ST_UP;
                value_d = VAL_ONE;
            end else if (MODE == MODE_UPWRAP) begin
                state_d = ST_UP;
                value_d = '0;
            end else begin
                state_d = ST_DOWN;
                value_d = VAL_MAX;
            end
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        paused = (state_q == ST_PAUSED);
        case (state_q)
            ST_DOWN:   dir = 1'b0;
            ST_PAUSED: dir = saved_up_q;
            default:   dir = 1'b1;
        endcase
    end

    assign value = value_q;
    assign done  = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: ping-pong, pause, reset, up-wrap, down-wrap.
module tb_led_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go0 = 1'b0, pause0 = 1'b0;
    logic go1 = 1'b0, pause1 = 1'b0;
    logic go2 = 1'b0, pause2 = 1'b0;
    logic [1:0] v0, v1, v2;
    logic d0, b0, p0, dn0;
    logic d1, b1, p1, dn1;
    logic d2, b2, p2, dn2;

    int n_checks = 0;
    int n_fail   = 0;

    // Ping-pong values after edges 1..19 (go sampled at edge 1).
    localparam int PP_V[19] = '{0,0,1,1,2,2,3,3,2,2,2,1,1,1,0,0,0,0,0};
    // Up-wrap, two rounds, values after edges 1..18.
    localparam int UW_V[18] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3,0,0};

    always #5 clk = ~clk;

    led_sequencer #(.WIDTH(2), .UP_DIV(2), .DOWN_DIV(3), .MODE(0), .ROUNDS(1)) dut0 (
        .clk(clk), .rst(rst), .go(go0), .pause(pause0),
        .value(v0), .dir(d0), .busy(b0), .paused(p0), .done(dn0));

    led_sequencer #(.WIDTH(2), .UP_DIV(2), .DOWN_DIV(3), .MODE(1), .ROUNDS(2)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .pause(pause1),
        .value(v1), .dir(d1), .busy(b1), .paused(p1), .done(dn1));

    led_sequencer #(.WIDTH(2), .UP_DIV(2), .DOWN_DIV(3), .MODE(2), .ROUNDS(0)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .pause(pause2),
        .value(v2), .dir(d2), .busy(b2), .paused(p2), .done(dn2));

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Let dut0 run out to IDLE, bounded.
    task automatic drain0();
        int cyc;
        cyc = 0;
        while (b0 === 1'b1 && cyc < 60) begin
            step(1);
            cyc++;
        end
        n_checks++;
        if (b0 !== 1'b0) begin
            n_fail++;
            $display("FAIL drain0_timeout: busy=%0b want 0", b0);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({v0, d0, b0, p0, dn0} !== 6'b00_1000) begin
            n_fail++;
            $display("FAIL reset_dut0: v=%0d dir=%0b busy=%0b paused=%0b done=%0b want 0,1,0,0,0", v0, d0, b0, p0, dn0);
        end
        n_checks++;
        if ({v1, d1, b1, p1, dn1, v2, d2, b2, p2, dn2} !== 12'b00_1000_00_1000) begin
            n_fail++;
            $display("FAIL reset_dut12: v1=%0d b1=%0b v2=%0d b2=%0b want idle", v1, b1, v2, b2);
        end
        step(2);
        rst = 1'b0;
        step(3);
        n_checks++;
        if ({v0, d0, b0} !== 4'b00_10) begin
            n_fail++;
            $display("FAIL idle_after_release: v=%0d dir=%0b busy=%0b want 0,1,0", v0, d0, b0);
        end
    endtask

    task automatic test_pingpong();
        go0 = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step(1);
            go0 = 1'b0;
            n_checks++;
            if (v0 !== 2'(PP_V[i-1])) begin
                n_fail++;
                $display("FAIL pp_value e%0d: got %0d want %0d", i, v0, PP_V[i-1]);
            end
            n_checks++;
            if (b0 !== (i <= 17) || dn0 !== (i == 18) || d0 !== !(i >= 9 && i <= 17)) begin
                n_fail++;
                $display("FAIL pp_status e%0d: busy=%0b done=%0b dir=%0b want %0b,%0b,%0b",
                         i, b0, dn0, d0, (i <= 17), (i == 18), !(i >= 9 && i <= 17));
            end
        end
    endtask

    task automatic test_pause_mid();
        go0 = 1'b1;
        step(1);
        go0 = 1'b0;
        step(4);
        pause0 = 1'b1;
        step(1);
        pause0 = 1'b0;
        n_checks++;
        if ({v0, p0, b0, d0} !== 5'b10_111) begin
            n_fail++;
            $display("FAIL pmid_enter: v=%0d paused=%0b busy=%0b dir=%0b want 2,1,1,1", v0, p0, b0, d0);
        end
        step(9);
        n_checks++;
        if ({v0, p0} !== 3'b10_1) begin
            n_fail++;
            $display("FAIL pmid_hold: v=%0d paused=%0b want 2,1", v0, p0);
        end
        pause0 = 1'b1;
        step(1);
        pause0 = 1'b0;
        n_checks++;
        if ({v0, p0, d0} !== 4'b10_01) begin
            n_fail++;
            $display("FAIL pmid_resume: v=%0d paused=%0b dir=%0b want 2,0,1", v0, p0, d0);
        end
        step(1);
        n_checks++;
        if (v0 !== 2'd2) begin
            n_fail++;
            $display("FAIL pmid_remaining: v=%0d want 2", v0);
        end
        step(1);
        n_checks++;
        if (v0 !== 2'd3) begin
            n_fail++;
            $display("FAIL pmid_step: v=%0d want 3", v0);
        end
        drain0();
    endtask

    task automatic test_pause_tick();
        go0 = 1'b1;
        step(1);
        go0 = 1'b0;
        step(3);
        pause0 = 1'b1;
        step(1);
        pause0 = 1'b0;
        n_checks++;
        if ({v0, p0} !== 3'b01_1) begin
            n_fail++;
            $display("FAIL ptick_enter: v=%0d paused=%0b want 1,1", v0, p0);
        end
        step(5);
        pause0 = 1'b1;
        step(1);
        pause0 = 1'b0;
        n_checks++;
        if ({v0, p0} !== 3'b01_0) begin
            n_fail++;
            $display("FAIL ptick_resume: v=%0d paused=%0b want 1,0", v0, p0);
        end
        step(1);
        n_checks++;
        if (v0 !== 2'd2) begin
            n_fail++;
            $display("FAIL ptick_step: v=%0d want 2", v0);
        end
        drain0();
    endtask

    task automatic test_reset_mid();
        go0 = 1'b1;
        step(1);
        go0 = 1'b0;
        step(9);
        n_checks++;
        if ({v0, d0, b0} !== 4'b10_01) begin
            n_fail++;
            $display("FAIL rmid_pre: v=%0d dir=%0b busy=%0b want 2,0,1", v0, d0, b0);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({v0, d0, b0, p0, dn0} !== 6'b00_1000) begin
            n_fail++;
            $display("FAIL rmid_async: v=%0d dir=%0b busy=%0b paused=%0b done=%0b want 0,1,0,0,0", v0, d0, b0, p0, dn0);
        end
        rst = 1'b0;
        step(3);
        n_checks++;
        if ({v0, b0} !== 3'b00_0) begin
            n_fail++;
            $display("FAIL rmid_no_restart: v=%0d busy=%0b want 0,0", v0, b0);
        end
        go0 = 1'b1;
        step(1);
        go0 = 1'b0;
        step(2);
        n_checks++;
        if ({v0, d0, b0} !== 4'b01_11) begin
            n_fail++;
            $display("FAIL rmid_restart: v=%0d dir=%0b busy=%0b want 1,1,1", v0, d0, b0);
        end
        drain0();
    endtask

    task automatic test_upwrap();
        go1 = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step(1);
            go1 = (i == 11);  // stray go sampled at edge 12, mid-run
            n_checks++;
            if (v1 !== 2'(UW_V[i-1])) begin
                n_fail++;
                $display("FAIL uw_value e%0d: got %0d want %0d", i, v1, UW_V[i-1]);
            end
            n_checks++;
            if (b1 !== (i <= 16) || dn1 !== (i == 17) || d1 !== 1'b1) begin
                n_fail++;
                $display("FAIL uw_status e%0d: busy=%0b done=%0b dir=%0b want %0b,%0b,1",
                         i, b1, dn1, d1, (i <= 16), (i == 17));
            end
        end
        go1 = 1'b0;
    endtask

    task automatic test_downwrap();
        int seen_done;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        pause2 = 1'b1;
        step(1);
        pause2 = 1'b0;
        step(2);
        n_checks++;
        if ({v2, b2, p2, d2} !== 5'b00_001) begin
            n_fail++;
            $display("FAIL dw_idle_pause: v=%0d busy=%0b paused=%0b dir=%0b want 0,0,0,1", v2, b2, p2, d2);
        end
        seen_done = 0;
        go2 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            go2 = 1'b0;
            if (dn2 !== 1'b0) seen_done++;
            n_checks++;
            if (v2 !== 2'(3 - (((i - 1) / 3) % 4)) || b2 !== 1'b1 || d2 !== 1'b0) begin
                n_fail++;
                $display("FAIL dw_step e%0d: v=%0d busy=%0b dir=%0b want %0d,1,0",
                         i, v2, b2, d2, 3 - (((i - 1) / 3) % 4));
            end
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL dw_done: done seen %0d cycles want 0", seen_done);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pingpong();
        step(2);
        test_pause_mid();
        step(2);
        test_pause_tick();
        step(2);
        test_reset_mid();
        step(2);
        test_upwrap();
        step(2);
        test_downwrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
